sensor_trace_engine: RTL and testbench
======================================

# sensor_trace_engine

Holds per-tracer injection tables and overlays traced values onto the sensor sample stream. It consumes the configuration produced by the tracer AXI register block: tracer_enable, tracer_index, wr_tracer_cell with its write strobe, and returns rd_tracer_cell. It sits inline on the 8-lane sensor stream between the sensor front end and the downstream packetizer.

## Interface
- DEPTH, 16: cells per tracer table; power of two, 2..256.
- LANES, 8: sensor lanes; fixed at 8, one tracer per lane.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- tracer_enable  in  8  bit i enables tracer i for lane i.
- tracer_index  in  3  tracer selected for host cell write/readback.
- wr_tracer_cell  in  32  host cell word: [15:0] value, [23:16] cell address, [31] last flag.
- wr_tracer_cell_wstrobe  in  1  one-cycle pulse; writes wr_tracer_cell into table tracer_index.
- rd_tracer_cell  out  32  readback of the selected tracer's cell at its last-written address.
- in_tdata  in  128  sensor beat; lane i = [16i+15:16i].
- in_tuser  in  1  frame-start flag on the first beat of a frame.
- in_tvalid  in  1  input valid.
- in_tready  out  1  input ready.
- out_tdata  out  128  beat with traced lanes overridden.
- out_tuser  out  1  in_tuser passed through with the beat.
- out_tvalid  out  1  output valid.
- out_tready  in  1  downstream ready.

## Operation
- Tables: 8 × DEPTH cells, each 17 bits ({last, value}), implemented in registers.
- Host write: on a wstrobe, cell[tracer_index][addr mod DEPTH] <= {wdata[31], wdata[15:0]}.
  - The tracer's last_addr register <= addr mod DEPTH.
  - Address bits at or above log2(DEPTH) are ignored.
- Readback register: rd_tracer_cell = {last, 7'b0, 8'(last_addr[tracer_index]), value}, taken from cell[tracer_index][last_addr[tracer_index]].
- Injection state per tracer: active bit and cell pointer ptr (log2(DEPTH) bits).
- Frame-start beat accepted (in_tvalid & in_tready & in_tuser):
  - active[i] <= tracer_enable[i].
  - Enabled lanes use cell 0 on this beat.
  - Next ptr is computed from cell 0 by the advance rule.
- Advance rule, on each other accepted beat: for active tracer i, lane i = cell[i][ptr].value, then ptr <= (cell.last or ptr==DEPTH-1) ? 0 : ptr+1.
- Lanes of inactive tracers pass through unchanged.
- Mid-frame tracer_enable changes are ignored until the next frame start.
- Beats before the first frame start after reset pass through untouched, because every active bit is 0.

## Timing
- Reset values: in_tready 1, out_tvalid 0, out_tdata 0, out_tuser 0, rd_tracer_cell 0. All cells, last_addr, ptr and active clear to 0.
- Stream path: one register stage, latency 1 cycle.
  - in_tready = !out_tvalid | out_tready (combinational).
  - A beat presented with in_tvalid & in_tready appears on out_* the next cycle.
  - Back-to-back beats sustain full throughput.
- Stalls:
  - out_tvalid & !out_tready holds out_tdata, out_tuser and all ptr values.
  - out_* must not change while out_tvalid & !out_tready.
- Host write vs stream read of the same cell in the same cycle: the stream beat uses the old value. The new value is visible from the next cycle.
- rd_tracer_cell updates 1 cycle after a wstrobe or a tracer_index change.
- Reset asserted mid-frame: output drops immediately and beats in flight are lost. Tables clear, so the host must reload them.

## Structure
- Shared package sensor_trace_pkg holds:
  - LANES, cell field positions (VAL_LSB/MSB, ADDR_LSB/MSB, LAST_BIT), lane width 16.
  - A cell struct {last, value}.
- Sub-module trace_table instanced 8× (DEPTH cells, host write port, combinational read at ptr and at last_addr, owns ptr/active).
- The top level holds the pipeline register and the lane mux.

## Test plan
- Load tracer 2: cells 0..3 = 0x1111, 0x2222, 0x3333, 0x4444 (last on cell 3). Enable = 0x04, then send a frame of 6 beats with in_tdata lanes = 0xAAAA. Required: lane 2 carries 1111, 2222, 3333, 4444, 1111, 2222; all other lanes carry AAAA; latency 1.
- No last flag anywhere, DEPTH=16, 20-beat frame. Required: the pointer wraps 15→0; beat 16 carries cell 0.
- Raise tracer_enable=0x01 mid-frame. Required: lane 0 unchanged until the next tuser beat, then carries cell 0.
- Hold out_tready low for 3 cycles mid-frame. Required: out_tdata stable and in_tready=0 during the stall; the sequence resumes without skipped or repeated cells.
- Write 0x8005BEEF with tracer_index=5. Required: rd_tracer_cell=0x8005BEEF one cycle later. Then switch to index 4 (never written): rd=0.
- Assert reset during beat 3 of a frame. Required: out_tvalid=0 asynchronously, rd=0, and all lanes pass through after release.

Source files
------------

// File: rtl/sensor_trace_engine_pkg.sv
// Shared definitions for the sensor trace engine: lane geometry, host cell word layout
// and the stored cell format.
package sensor_trace_pkg;

  localparam int LANES    = 8;
  localparam int LANE_W   = 16;
  localparam int DATA_W   = LANES * LANE_W;
  localparam int VAL_LSB  = 0;
  localparam int VAL_MSB  = 15;
  localparam int ADDR_LSB = 16;
  localparam int ADDR_MSB = 23;
  localparam int LAST_BIT = 31;

  typedef struct packed {
    logic              last;
    logic [LANE_W-1:0] value;
  } cell_t;

  function automatic cell_t word_to_cell(input logic [31:0] word);
    cell_t c;
    c.last  = word[LAST_BIT];
    c.value = word[VAL_MSB:VAL_LSB];
    return c;
  endfunction

  function automatic logic [31:0] cell_to_word(input cell_t c, input logic [7:0] addr);
    return {c.last, 7'b0000000, addr, c.value};
  endfunction

endpackage

// File: rtl/sensor_trace_engine_if.sv
// 8-lane sensor stream bundle with valid/ready handshake and frame-start user flag.
interface sensor_trace_engine_if;
  import sensor_trace_pkg::*;

  logic [DATA_W-1:0] tdata;
  logic              tuser;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tuser, output tvalid, input tready);
  modport slave  (input tdata, input tuser, input tvalid, output tready);

endinterface

// File: rtl/sensor_trace_engine_table.sv
// One tracer: register-based cell table with host write port, readback at the
// last-written address, and the per-frame injection pointer.
module trace_table
  import sensor_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  cell_t             i_wr_cell,
  input  logic              i_beat,
  input  logic              i_frame_start,
  input  logic              i_enable,
  output logic              o_active,
  output logic [LANE_W-1:0] o_value,
  output cell_t             o_rd_cell,
  output logic [AW-1:0]     o_last_addr
);

  cell_t         r_cells [DEPTH];
  logic [AW-1:0] r_last_addr;
  logic [AW-1:0] r_ptr;
  logic          r_active;

  logic [AW-1:0] w_cur_ptr;
  logic          w_cur_active;
  cell_t         w_cur_cell;
  logic [AW-1:0] w_next_ptr;

  // Host writes land in the table at the edge, so a same-cycle stream read sees the old cell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_cells[k] <= '0;
      end
      r_last_addr <= '0;
    end else if (i_wr_en) begin
      r_cells[i_wr_addr] <= i_wr_cell;
      r_last_addr        <= i_wr_addr;
    end
  end

  // Cell used by the current beat and the pointer that follows it.
  always_comb begin
    w_cur_ptr    = r_ptr;
    w_cur_active = r_active;
    if (i_frame_start) begin
      w_cur_ptr    = '0;
      w_cur_active = i_enable;
    end else begin
      w_cur_ptr    = r_ptr;
      w_cur_active = r_active;
    end
    w_cur_cell = r_cells[w_cur_ptr];
    if (w_cur_cell.last || (w_cur_ptr == AW'(DEPTH - 1))) begin
      w_next_ptr = '0;
    end else begin
      w_next_ptr = w_cur_ptr + AW'(1);
    end
  end

  // Injection state only moves on accepted beats, so stalls freeze the pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active <= 1'b0;
      r_ptr    <= '0;
    end else if (i_beat) begin
      r_active <= w_cur_active;
      if (w_cur_active) begin
        r_ptr <= w_next_ptr;
      end else begin
        r_ptr <= '0;
      end
    end
  end

  assign o_active    = w_cur_active;
  assign o_value     = w_cur_cell.value;
  assign o_rd_cell   = r_cells[r_last_addr];
  assign o_last_addr = r_last_addr;

endmodule

// File: rtl/sensor_trace_engine.sv
// Inline tracer overlay on the 8-lane sensor stream: eight trace tables, the lane
// override mux, a single output register stage and the host readback register.
module sensor_trace_engine
  import sensor_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES-1:0]       i_tracer_enable,
  input  logic [2:0]             i_tracer_index,
  input  logic [31:0]            i_wr_tracer_cell,
  input  logic                   i_wr_tracer_cell_wstrobe,
  output logic [31:0]            o_rd_tracer_cell,
  sensor_trace_engine_if.slave   s_in,
  sensor_trace_engine_if.master  m_out
);

  localparam int AW = $clog2(DEPTH);

  logic              w_in_ready;
  logic              w_accept;
  logic              w_frame_start;
  logic [AW-1:0]     w_wr_addr;
  cell_t             w_wr_cell;
  logic [LANES-1:0]  w_active;
  logic [LANE_W-1:0] w_value     [LANES];
  cell_t             w_rd_cell   [LANES];
  logic [AW-1:0]     w_last_addr [LANES];
  logic [DATA_W-1:0] w_out_data;
  logic [31:0]       w_rd_word;
  logic              w_unused;

  logic [DATA_W-1:0] r_out_data;
  logic              r_out_user;
  logic              r_out_valid;
  logic [31:0]       r_rd_word;

  assign w_in_ready    = !r_out_valid || m_out.tready;
  assign w_accept      = s_in.tvalid && w_in_ready;
  assign w_frame_start = w_accept && s_in.tuser;
  assign w_wr_addr     = i_wr_tracer_cell[ADDR_LSB +: AW];
  assign w_wr_cell     = word_to_cell(i_wr_tracer_cell);
  assign w_unused      = ^i_wr_tracer_cell;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    trace_table #(.DEPTH(DEPTH)) u_table (
      .clk           (clk),
      .rst           (rst),
      .i_wr_en       (i_wr_tracer_cell_wstrobe && (i_tracer_index == 3'(g))),
      .i_wr_addr     (w_wr_addr),
      .i_wr_cell     (w_wr_cell),
      .i_beat        (w_accept),
      .i_frame_start (w_frame_start),
      .i_enable      (i_tracer_enable[g]),
      .o_active      (w_active[g]),
      .o_value       (w_value[g]),
      .o_rd_cell     (w_rd_cell[g]),
      .o_last_addr   (w_last_addr[g])
    );

    assign w_out_data[g*LANE_W +: LANE_W] =
      w_active[g] ? w_value[g] : s_in.tdata[g*LANE_W +: LANE_W];
  end

  // A write bypasses into readback so the new cell shows one cycle after the strobe.
  always_comb begin
    w_rd_word = '0;
    if (i_wr_tracer_cell_wstrobe) begin
      w_rd_word = cell_to_word(w_wr_cell, 8'(w_wr_addr));
    end else begin
      w_rd_word = cell_to_word(w_rd_cell[i_tracer_index], 8'(w_last_addr[i_tracer_index]));
    end
  end

  // Single output stage; holds while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_user  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_data  <= w_out_data;
      r_out_user  <= s_in.tuser;
      r_out_valid <= 1'b1;
    end else if (m_out.tready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Host readback register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_word <= '0;
    end else begin
      r_rd_word <= w_rd_word;
    end
  end

  assign s_in.tready      = w_in_ready;
  assign m_out.tdata      = r_out_data;
  assign m_out.tuser      = r_out_user;
  assign m_out.tvalid     = r_out_valid;
  assign o_rd_tracer_cell = r_rd_word;

endmodule

// File: tb/tb_sensor_trace_engine.sv
// Directed, self-checking bench for sensor_trace_engine.
module tb_sensor_trace_engine;
  import sensor_trace_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  tracer_enable;
  logic [2:0]  tracer_index;
  logic [31:0] wr_cell;
  logic        wr_strobe;
  logic [31:0] rd_cell;

  sensor_trace_engine_if u_in_if ();
  sensor_trace_engine_if u_out_if ();

  sensor_trace_engine #(.DEPTH(16)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .i_tracer_enable          (tracer_enable),
    .i_tracer_index           (tracer_index),
    .i_wr_tracer_cell         (wr_cell),
    .i_wr_tracer_cell_wstrobe (wr_strobe),
    .o_rd_tracer_cell         (rd_cell),
    .s_in                     (u_in_if),
    .m_out                    (u_out_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [127:0] in_data;
    logic         in_user;
    logic [127:0] exp_data;
    logic         exp_user;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [127:0] lanes_with(input logic [15:0] base, input int lane,
                                              input logic [15:0] v);
    logic [127:0] r;
    r = {8{base}};
    r[lane*16 +: 16] = v;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [2:0] idx, input logic [31:0] word);
    tracer_index = idx;
    wr_cell      = word;
    wr_strobe    = 1'b1;
    tick();
    wr_strobe    = 1'b0;
  endtask

  task automatic send(input logic [127:0] data, input logic user);
    u_in_if.tvalid = 1'b1;
    u_in_if.tdata  = data;
    u_in_if.tuser  = user;
    tick();
  endtask

  task automatic idle();
    u_in_if.tvalid = 1'b0;
    u_in_if.tuser  = 1'b0;
    tick();
  endtask

  task automatic chk_beat(input string name, input logic [127:0] exp);
    chk({name, " valid"}, u_out_if.tvalid, 1'b1);
    chk({name, " data"}, u_out_if.tdata, exp);
  endtask

  initial begin
    rst             = 1'b1;
    tracer_enable   = 8'h00;
    tracer_index    = 3'd0;
    wr_cell         = 32'h0;
    wr_strobe       = 1'b0;
    u_in_if.tvalid  = 1'b0;
    u_in_if.tdata   = 128'h0;
    u_in_if.tuser   = 1'b0;
    u_out_if.tready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    chk("reset in_tready", u_in_if.tready, 1'b1);
    chk("reset out_tvalid", u_out_if.tvalid, 1'b0);
    chk("reset out_tdata", u_out_if.tdata, 128'h0);
    chk("reset out_tuser", u_out_if.tuser, 1'b0);
    chk("reset rd", rd_cell, 32'h0);

    // Before any frame start every lane passes through.
    send({8{16'hC3C3}}, 1'b0);
    chk_beat("pre-frame passthrough", {8{16'hC3C3}});
    idle();

    // Tracer 2, four cells, last flag on cell 3.
    host_write(3'd2, 32'h0000_1111);
    host_write(3'd2, 32'h0001_2222);
    host_write(3'd2, 32'h0002_3333);
    host_write(3'd2, 32'h8003_4444);
    tracer_enable = 8'h04;
    vecs[0] = '{{8{16'hAAAA}}, 1'b1, lanes_with(16'hAAAA, 2, 16'h1111), 1'b1};
    vecs[1] = '{{8{16'hAAAA}}, 1'b0, lanes_with(16'hAAAA, 2, 16'h2222), 1'b0};
    vecs[2] = '{{8{16'hAAAA}}, 1'b0, lanes_with(16'hAAAA, 2, 16'h3333), 1'b0};
    vecs[3] = '{{8{16'hAAAA}}, 1'b0, lanes_with(16'hAAAA, 2, 16'h4444), 1'b0};
    vecs[4] = '{{8{16'hAAAA}}, 1'b0, lanes_with(16'hAAAA, 2, 16'h1111), 1'b0};
    vecs[5] = '{{8{16'hAAAA}}, 1'b0, lanes_with(16'hAAAA, 2, 16'h2222), 1'b0};
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].in_data, vecs[i].in_user);
      chk_beat($sformatf("t2 beat%0d", i), vecs[i].exp_data);
      chk($sformatf("t2 beat%0d user", i), u_out_if.tuser, vecs[i].exp_user);
    end
    idle();
    chk("idle out_tvalid", u_out_if.tvalid, 1'b0);

    // Tracer 3, all 16 cells without last: pointer wraps 15 -> 0.
    for (int k = 0; k < 16; k++) begin
      host_write(3'd3, 32'h0000_3000 | (32'(k) << 16) | 32'(k));
    end
    tracer_enable = 8'h08;
    for (int j = 0; j < 20; j++) begin
      send({8{16'h5555}}, j == 0);
      chk_beat($sformatf("wrap beat%0d", j), lanes_with(16'h5555, 3, 16'h3000 + 16'(j % 16)));
    end
    idle();

    // Tracer 0: enable raised mid-frame waits for the next frame start.
    host_write(3'd0, 32'h0000_0A00);
    host_write(3'd0, 32'h8001_0A01);
    tracer_enable = 8'h00;
    send({8{16'h1234}}, 1'b1);
    chk_beat("midframe b0", {8{16'h1234}});
    tracer_enable = 8'h01;
    send({8{16'h1234}}, 1'b0);
    chk_beat("midframe b1", {8{16'h1234}});
    send({8{16'h1234}}, 1'b0);
    chk_beat("midframe b2", {8{16'h1234}});
    send({8{16'h1234}}, 1'b1);
    chk_beat("next frame c0", lanes_with(16'h1234, 0, 16'h0A00));
    send({8{16'h1234}}, 1'b0);
    chk_beat("next frame c1", lanes_with(16'h1234, 0, 16'h0A01));
    send({8{16'h1234}}, 1'b0);
    chk_beat("next frame c0 again", lanes_with(16'h1234, 0, 16'h0A00));
    idle();

    // Downstream stall of 3 cycles mid-frame on tracer 2.
    tracer_enable = 8'h04;
    send({8{16'h9999}}, 1'b1);
    chk_beat("stall b0", lanes_with(16'h9999, 2, 16'h1111));
    send({8{16'h9999}}, 1'b0);
    chk_beat("stall b1", lanes_with(16'h9999, 2, 16'h2222));
    u_out_if.tready = 1'b0;
    u_in_if.tuser   = 1'b0;
    #1;
    chk("stall in_tready", u_in_if.tready, 1'b0);
    for (int s = 0; s < 3; s++) begin
      tick();
      chk_beat($sformatf("stall hold%0d", s), lanes_with(16'h9999, 2, 16'h2222));
      chk($sformatf("stall hold%0d in_tready", s), u_in_if.tready, 1'b0);
    end
    u_out_if.tready = 1'b1;
    tick();
    chk_beat("stall resume b2", lanes_with(16'h9999, 2, 16'h3333));
    send({8{16'h9999}}, 1'b0);
    chk_beat("stall resume b3", lanes_with(16'h9999, 2, 16'h4444));
    send({8{16'h9999}}, 1'b0);
    chk_beat("stall resume b4", lanes_with(16'h9999, 2, 16'h1111));
    idle();

    // Readback after a write, on an unwritten tracer, and with upper address bits.
    host_write(3'd5, 32'h8005_BEEF);
    chk("rd after write", rd_cell, 32'h8005_BEEF);
    tracer_index = 3'd4;
    tick();
    chk("rd unwritten tracer", rd_cell, 32'h0);
    host_write(3'd5, 32'h00F3_0042);
    chk("rd addr wrap bypass", rd_cell, 32'h0003_0042);
    tick();
    chk("rd addr wrap table", rd_cell, 32'h0003_0042);

    // Reset during beat 3 of a frame.
    tracer_enable = 8'h04;
    send({8{16'h7777}}, 1'b1);
    chk_beat("rst b0", lanes_with(16'h7777, 2, 16'h1111));
    send({8{16'h7777}}, 1'b0);
    chk_beat("rst b1", lanes_with(16'h7777, 2, 16'h2222));
    u_in_if.tdata = {8{16'h7777}};
    #2;
    rst = 1'b1;
    #1;
    chk("rst async out_tvalid", u_out_if.tvalid, 1'b0);
    chk("rst async out_tdata", u_out_if.tdata, 128'h0);
    chk("rst async rd", rd_cell, 32'h0);
    tick();
    rst           = 1'b0;
    tracer_enable = 8'h00;
    send({8{16'h6666}}, 1'b0);
    chk_beat("post-rst passthrough0", {8{16'h6666}});
    send({8{16'h6565}}, 1'b0);
    chk_beat("post-rst passthrough1", {8{16'h6565}});
    chk("post-rst rd", rd_cell, 32'h0);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
